interprete_senales: RTL and testbench
=====================================

// Module: interprete_senales
// PURPOSE
//  Sits directly downstream of the button/sensor debounce-and-toggle stage. Consumes its
//  toggle-level outputs (each debounced press/detection flips one level), turns every level
//  change into a one-cycle event, and runs the pet's mode FSM (NORMAL/TEST/DORMIR).
//  Emits rate-limited single-cycle action pulses to the pet state machine.
// PARAMETERS
//  COOLDOWN  5  cycles action events are ignored after an action pulse (synthesis: 50000000)
//  N_TEST    4  number of test-mode pet states; test_idx wraps N_TEST-1 -> 0
//  IDX_W     2  width of test_idx; must satisfy 2**IDX_W >= N_TEST
// PORTS
//  clk             in   1      system clock, all logic on rising edge
//  reset_tmp       in   1      reset, asynchronous, active-high
//  senal_test      in   1      toggle level: test button
//  senal_energia   in   1      toggle level: energy button
//  senal_medicina  in   1      toggle level: medicine button
//  senal_fot       in   1      toggle level: photocell (light/dark change)
//  senal_ult       in   1      toggle level: ultrasonic presence detection
//  modo            out  2      00 NORMAL, 01 TEST, 10 DORMIR (11 unused, never driven)
//  test_idx        out  IDX_W  selected pet state while in TEST
//  accion_energia  out  1      1-cycle pulse: feed/energy action
//  accion_medicina out  1      1-cycle pulse: medicine action
//  interaccion     out  1      1-cycle pulse: ultrasonic interaction while awake
//  despertar       out  1      1-cycle pulse: woken from DORMIR by ultrasonic
//  test_avanza     out  1      1-cycle pulse: test_idx advanced
// BEHAVIOUR
//  Reset (async): all outputs 0, modo=NORMAL, test_idx=0, cooldown=0, sync/prev flops=0, arm cnt=0.
//  Input path per signal: 2-FF synchronizer -> prev flop; event = sync2 XOR prev.
//  Event-to-output latency: pulse is registered; it is high exactly one cycle, starting after
//   the 3rd rising edge following the input level change.
//  Arming: events are suppressed for the first 3 cycles after reset_tmp deassertion (flops fill
//   with current levels); non-zero input levels at reset release never produce events.
//  Priority per cycle: test > fot > ult > medicina > energia. Only the highest-priority valid
//   event is acted upon; lower simultaneous events are dropped (no queueing).
//  FSM:
//   NORMAL: test -> TEST (test_idx=0); fot -> DORMIR; ult -> interaccion;
//           medicina -> accion_medicina; energia -> accion_energia.
//   TEST:   test -> NORMAL; energia -> test_idx+1 (wrap N_TEST-1 -> 0) + test_avanza;
//           fot, ult, medicina ignored.
//   DORMIR: fot -> NORMAL; ult -> NORMAL + despertar; test -> TEST (test_idx=0);
//           energia/medicina ignored.
//  Cooldown: accion_energia, accion_medicina, interaccion load cnt=COOLDOWN; cnt decrements to 0.
//   While cnt!=0, ult/medicina/energia events in NORMAL are dropped (test, fot, TEST-mode
//   energia, DORMIR ult unaffected). Any modo change clears cnt to 0.
//  test_idx holds its value in NORMAL/DORMIR; reset only by reset_tmp or TEST entry.
//  Reset mid-operation: immediate return to reset values; pending pulses are aborted.
// TESTING
//  1 Hold senal_*=1 through reset release -> no pulse in next 10 cycles, modo=00.
//  2 Toggle senal_energia at cycle 10 -> accion_energia=1 for exactly one cycle after edge 13.
//  3 Two energia toggles 2 cycles apart (COOLDOWN=5) -> one pulse only; 3rd toggle 8 cycles
//    after first pulse -> second pulse.
//  4 test toggle -> modo=01; 5 energia toggles (spaced >=4 cycles) -> test_idx 1,2,3,0,1 with
//    5 test_avanza pulses; test toggle -> modo=00, test_idx stays 1.
//  5 fot toggle -> modo=10; energia toggle -> no pulse; ult toggle -> despertar pulse, modo=00.
//  6 medicina and test toggled same cycle in NORMAL -> modo=01, no accion_medicina;
//    reset_tmp asserted mid-pulse -> all outputs 0 same cycle.

Source files
------------

// File: rtl/interprete_senales.sv
// rtl/interprete_senales.sv - toggle-level inputs to edge events, pet mode FSM, rate-limited action pulses
// Each input toggle becomes a one-cycle event; the strongest event per cycle drives the mode/action logic.

module interprete_senales #(
  parameter int COOLDOWN = 5,
  parameter int N_TEST   = 4,
  parameter int IDX_W    = 2
) (
  input  logic             clk,
  input  logic             reset_tmp,
  input  logic             senal_test,
  input  logic             senal_energia,
  input  logic             senal_medicina,
  input  logic             senal_fot,
  input  logic             senal_ult,
  output logic [1:0]       modo,
  output logic [IDX_W-1:0] test_idx,
  output logic             accion_energia,
  output logic             accion_medicina,
  output logic             interaccion,
  output logic             despertar,
  output logic             test_avanza
);

  localparam int CNT_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TEST - 1);

  // Bit positions inside the event vectors, highest index = highest priority.
  localparam int B_TEST = 4;
  localparam int B_FOT  = 3;
  localparam int B_ULT  = 2;
  localparam int B_MED  = 1;
  localparam int B_EN   = 0;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    TEST   = 2'b01,
    DORMIR = 2'b10
  } modo_t;

  logic [4:0]       senal_in;
  logic [4:0]       sync1_q, sync1_d;
  logic [4:0]       sync2_q, sync2_d;
  logic [4:0]       prev_q, prev_d;
  logic [1:0]       arm_q, arm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  modo_t            modo_q, modo_d;
  logic [IDX_W-1:0] test_idx_q, test_idx_d;
  logic             accion_energia_q, accion_energia_d;
  logic             accion_medicina_q, accion_medicina_d;
  logic             interaccion_q, interaccion_d;
  logic             despertar_q, despertar_d;
  logic             test_avanza_q, test_avanza_d;

  logic             armed;
  logic             cooling;
  logic [4:0]       evt;

  assign senal_in = {senal_test, senal_fot, senal_ult, senal_medicina, senal_energia};
  assign armed    = (arm_q == 2'd3);
  assign cooling  = (cnt_q != '0);
  // Until the pipeline has filled with the post-reset levels, differences are not real toggles.
  assign evt      = armed ? (sync2_q ^ prev_q) : 5'b0;

  always_comb begin
    sync1_d           = senal_in;
    sync2_d           = sync1_q;
    prev_d            = sync2_q;
    arm_d             = armed ? arm_q : arm_q + 2'd1;
    cnt_d             = cooling ? cnt_q - CNT_W'(1) : '0;
    modo_d            = modo_q;
    test_idx_d        = test_idx_q;
    accion_energia_d  = 1'b0;
    accion_medicina_d = 1'b0;
    interaccion_d     = 1'b0;
    despertar_d       = 1'b0;
    test_avanza_d     = 1'b0;

    if (evt[B_TEST]) begin
      case (modo_q)
        TEST: modo_d = NORMAL;
        NORMAL, DORMIR: begin
          modo_d     = TEST;
          test_idx_d = '0;
        end
        default: ;
      endcase
    end else if (evt[B_FOT]) begin
      case (modo_q)
        NORMAL:  modo_d = DORMIR;
        DORMIR:  modo_d = NORMAL;
        default: ;
      endcase
    end else if (evt[B_ULT]) begin
      case (modo_q)
        NORMAL: begin
          if (!cooling) begin
            interaccion_d = 1'b1;
            cnt_d         = CNT_LOAD;
          end
        end
        DORMIR: begin
          modo_d      = NORMAL;
          despertar_d = 1'b1;
        end
        default: ;
      endcase
    end else if (evt[B_MED]) begin
      if (modo_q == NORMAL && !cooling) begin
        accion_medicina_d = 1'b1;
        cnt_d             = CNT_LOAD;
      end
    end else if (evt[B_EN]) begin
      case (modo_q)
        NORMAL: begin
          if (!cooling) begin
            accion_energia_d = 1'b1;
            cnt_d            = CNT_LOAD;
          end
        end
        TEST: begin
          test_idx_d    = (test_idx_q == IDX_LAST) ? '0 : test_idx_q + IDX_W'(1);
          test_avanza_d = 1'b1;
        end
        default: ;
      endcase
    end

    // A fresh mode starts without any leftover rate limit.
    if (modo_d != modo_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset_tmp) begin
    if (reset_tmp) begin
      sync1_q           <= '0;
      sync2_q           <= '0;
      prev_q            <= '0;
      arm_q             <= '0;
      cnt_q             <= '0;
      modo_q            <= NORMAL;
      test_idx_q        <= '0;
      accion_energia_q  <= 1'b0;
      accion_medicina_q <= 1'b0;
      interaccion_q     <= 1'b0;
      despertar_q       <= 1'b0;
      test_avanza_q     <= 1'b0;
    end else begin
      sync1_q           <= sync1_d;
      sync2_q           <= sync2_d;
      prev_q            <= prev_d;
      arm_q             <= arm_d;
      cnt_q             <= cnt_d;
      modo_q            <= modo_d;
      test_idx_q        <= test_idx_d;
      accion_energia_q  <= accion_energia_d;
      accion_medicina_q <= accion_medicina_d;
      interaccion_q     <= interaccion_d;
      despertar_q       <= despertar_d;
      test_avanza_q     <= test_avanza_d;
    end
  end

  assign modo            = modo_q;
  assign test_idx        = test_idx_q;
  assign accion_energia  = accion_energia_q;
  assign accion_medicina = accion_medicina_q;
  assign interaccion     = interaccion_q;
  assign despertar       = despertar_q;
  assign test_avanza     = test_avanza_q;

endmodule

// File: tb/tb_interprete_senales.sv
// tb/tb_interprete_senales.sv - directed and randomized checks of interprete_senales against a behavioural model

module tb_interprete_senales;

  localparam int COOLDOWN = 5;
  localparam int N_TEST   = 4;
  localparam int IDX_W    = 2;

  logic             clk = 1'b0;
  logic             reset_tmp;
  logic             s_test, s_en, s_med, s_fot, s_ult;
  logic [1:0]       modo;
  logic [IDX_W-1:0] test_idx;
  logic             accion_energia, accion_medicina, interaccion, despertar, test_avanza;

  always #5 clk = ~clk;

  interprete_senales #(.COOLDOWN(COOLDOWN), .N_TEST(N_TEST), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_tmp(reset_tmp),
    .senal_test(s_test), .senal_energia(s_en), .senal_medicina(s_med),
    .senal_fot(s_fot), .senal_ult(s_ult),
    .modo(modo), .test_idx(test_idx),
    .accion_energia(accion_energia), .accion_medicina(accion_medicina),
    .interaccion(interaccion), .despertar(despertar), .test_avanza(test_avanza)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: input levels seen at each rising edge since reset release, plus mode bookkeeping.
  int         k;
  logic [4:0] hist [0:4095];
  int         m_modo, m_idx, last_act;
  int         m_en, m_med, m_int, m_desp, m_av;
  int         cnt_en, cnt_med, cnt_int, cnt_desp, cnt_av;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; m_modo = 0; m_idx = 0; last_act = -100;
    m_en = 0; m_med = 0; m_int = 0; m_desp = 0; m_av = 0;
  endtask

  // A level change seen at edge j shows up as an event at edge j+2, acted on at that edge.
  task automatic model_edge();
    logic [4:0] ev;
    int top, old;
    bit blocked;
    k++;
    hist[k] = {s_test, s_fot, s_ult, s_med, s_en};
    m_en = 0; m_med = 0; m_int = 0; m_desp = 0; m_av = 0;
    if (k >= 4) begin
      ev = hist[k-2] ^ hist[k-3];
      top = -1;
      for (int b = 0; b < 5; b++) if (ev[b]) top = b;
      old = m_modo;
      blocked = (k - last_act) <= COOLDOWN;
      case (top)
        4: begin
          if (m_modo == 1) m_modo = 0;
          else begin m_modo = 1; m_idx = 0; end
        end
        3: begin
          if (m_modo == 0) m_modo = 2;
          else if (m_modo == 2) m_modo = 0;
        end
        2: begin
          if (m_modo == 0 && !blocked) begin m_int = 1; last_act = k; end
          else if (m_modo == 2) begin m_modo = 0; m_desp = 1; end
        end
        1: if (m_modo == 0 && !blocked) begin m_med = 1; last_act = k; end
        0: begin
          if (m_modo == 0 && !blocked) begin m_en = 1; last_act = k; end
          else if (m_modo == 1) begin m_idx = (m_idx + 1) % N_TEST; m_av = 1; end
        end
        default: ;
      endcase
      if (m_modo != old) last_act = -100;
    end
  endtask

  task automatic compare_all();
    check("modo", int'(modo), m_modo);
    check("test_idx", int'(test_idx), m_idx);
    check("accion_energia", int'(accion_energia), m_en);
    check("accion_medicina", int'(accion_medicina), m_med);
    check("interaccion", int'(interaccion), m_int);
    check("despertar", int'(despertar), m_desp);
    check("test_avanza", int'(test_avanza), m_av);
    cnt_en += int'(accion_energia); cnt_med += int'(accion_medicina);
    cnt_int += int'(interaccion); cnt_desp += int'(despertar); cnt_av += int'(test_avanza);
  endtask

  task automatic clear_counts();
    cnt_en = 0; cnt_med = 0; cnt_int = 0; cnt_desp = 0; cnt_av = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset(input int n);
    reset_tmp = 1'b1;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_all();
    end
    reset_tmp = 1'b0;
  endtask

  int exp_idx [5] = '{1, 2, 3, 0, 1};

  initial begin
    clear_counts();
    model_reset();
    s_test = 1; s_en = 1; s_med = 1; s_fot = 1; s_ult = 1;
    reset_tmp = 1'b1;
    @(negedge clk);

    // High levels held through reset release never produce events.
    do_reset(2);
    clear_counts();
    run(10);
    check("s1_pulses", cnt_en + cnt_med + cnt_int + cnt_desp + cnt_av, 0);
    check("s1_modo", int'(modo), 0);

    // Latency: pulse exactly after the 3rd rising edge following the change.
    s_en = ~s_en;
    cyc(); check("s2_lat1", int'(accion_energia), 0);
    cyc(); check("s2_lat2", int'(accion_energia), 0);
    cyc(); check("s2_lat3", int'(accion_energia), 1);
    cyc(); check("s2_lat4", int'(accion_energia), 0);
    run(8);

    // Cooldown swallows the second toggle; a later one gets through.
    clear_counts();
    s_en = ~s_en; run(2);
    s_en = ~s_en; run(8);
    check("s3_single", cnt_en, 1);
    s_en = ~s_en; run(6);
    check("s3_second", cnt_en, 2);

    // TEST mode index stepping with wrap.
    clear_counts();
    s_test = ~s_test; run(5);
    check("s4_modo_test", int'(modo), 1);
    for (int i = 0; i < 5; i++) begin
      s_en = ~s_en; run(4);
      check("s4_idx", int'(test_idx), exp_idx[i]);
    end
    check("s4_avanza", cnt_av, 5);
    s_test = ~s_test; run(5);
    check("s4_modo_back", int'(modo), 0);
    check("s4_idx_hold", int'(test_idx), 1);

    // DORMIR: energia ignored, ultrasonic wakes.
    clear_counts();
    s_fot = ~s_fot; run(5);
    check("s5_modo_dormir", int'(modo), 2);
    s_en = ~s_en; run(5);
    check("s5_no_energia", cnt_en, 0);
    s_ult = ~s_ult; run(5);
    check("s5_despertar", cnt_desp, 1);
    check("s5_modo_normal", int'(modo), 0);

    // Simultaneous medicina+test: test wins; then reset during a pulse.
    clear_counts();
    s_med = ~s_med; s_test = ~s_test; run(5);
    check("s6_modo_test", int'(modo), 1);
    check("s6_no_med", cnt_med, 0);
    s_test = ~s_test; run(5);
    s_en = ~s_en; run(3);
    check("s6_pulse_pre", int'(accion_energia), 1);
    reset_tmp = 1'b1;
    #1;
    check("s6_rst_en", int'(accion_energia), 0);
    check("s6_rst_modo", int'(modo), 0);
    check("s6_rst_idx", int'(test_idx), 0);
    do_reset(2);
    run(6);

    // Randomized toggling with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) s_test = ~s_test;
      if ($urandom_range(0, 5) == 0) s_en   = ~s_en;
      if ($urandom_range(0, 6) == 0) s_med  = ~s_med;
      if ($urandom_range(0, 9) == 0) s_fot  = ~s_fot;
      if ($urandom_range(0, 6) == 0) s_ult  = ~s_ult;
      if ($urandom_range(0, 400) == 0) do_reset($urandom_range(1, 3));
      else cyc();
      if (k > 4000) do_reset(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
